uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte producers (CPU path, DMA, loopback/test).
It sits between the producers and the register block's UART-side TX interface. Per transfer it:
- grants one requester and captures its byte;
- drives tx_data_out and issues a one-cycle start_tx;
- waits for the transmitter's done status, bounded by a timeout watchdog, before granting the next requester.

---
 rtl/uart_tx_scheduler.sv | 122 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Grants a requester, captures its byte, pulses start_tx and waits for a fresh tx_done edge.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data_out,
  output logic                 start_tx,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrant, StStart, StWaitDone} state_e;

  localparam logic [TO_W-1:0] WdogLast = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] IdReset  = ID_W'(NUM_REQ - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
  logic            tx_done_q;
  logic            done_evt;

  logic [ID_W-1:0] sel_id;
  logic            sel_found;
  int unsigned     idx;

  // Only a fresh low-to-high transition counts; a level left high is ignored.
  assign done_evt = tx_done & ~tx_done_q;

  // Scan from the requester after the last grant, wrapping, so the last winner goes last.
  always_comb begin
    sel_id    = grant_id_q;
    sel_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(grant_id_q) + i) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    wdog_d     = wdog_q;
    timeout_d  = 1'b0;
    req_ready  = '0;
    start_tx   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && sel_found) begin
          grant_id_d = sel_id;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        req_ready[grant_id_q] = 1'b1;
        if (req_valid[grant_id_q]) begin
          tx_data_d = req_data[int'(grant_id_q)*8 +: 8];
          state_d   = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        start_tx = 1'b1;
        wdog_d   = '0;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        wdog_d = wdog_q + TO_W'(1);
        if (done_evt) begin
          state_d = StIdle;
        end else if (wdog_q == WdogLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= StIdle;
      grant_id_q <= IdReset;
      tx_data_q  <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
      tx_done_q  <= tx_done;
    end
  end

  assign busy        = (state_q != StIdle);
  assign grant_id    = grant_id_q;
  assign tx_data_out = tx_data_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected grants, a monitor checks them.
module tb_uart_tx_scheduler;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdW    = 2;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              enable = 1'b0;
  logic [NumReq-1:0] req_valid = '0;
  logic [31:0]       req_data = 32'h433221A5;
  logic [NumReq-1:0] req_ready;
  logic [7:0]        tx_data_out;
  logic              start_tx;
  logic              tx_done = 1'b0;
  logic              busy;
  logic [IdW-1:0]    grant_id;
  logic              timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  int         exp_ready_q[$];
  int         exp_sid_q[$];
  logic [7:0] exp_sdata_q[$];
  int         exp_to_q[$];

  uart_tx_scheduler #(
    .NUM_REQ       (NumReq),
    .ID_W          (IdW),
    .TIMEOUT_CYCLES(16),
    .TO_W          (16)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_data_out(tx_data_out),
    .start_tx   (start_tx),
    .tx_done    (tx_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic expect_grant(input int id, input logic [7:0] data, input bit starts);
    exp_ready_q.push_back(id);
    if (starts) begin
      exp_sid_q.push_back(id);
      exp_sdata_q.push_back(data);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge pclk);
      if (start_tx) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL start_wait: no start_tx within 40 cycles, expected one");
    end
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_start"}, 32'(start_tx), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd3);
    check({tag, "_data"}, 32'(tx_data_out), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  // Monitor: every visible ready / start / timeout pops one expectation.
  int         mon_id;
  logic [7:0] mon_data;
  always @(negedge pclk) begin
    if (presetn) begin
      if (req_ready != '0) begin
        n_checks++;
        if (exp_ready_q.size() == 0) begin
          n_errors++;
          $display("FAIL ready_unexpected: got %b, expected none", req_ready);
        end else begin
          mon_id = exp_ready_q.pop_front();
          if (req_ready != (4'b0001 << mon_id)) begin
            n_errors++;
            $display("FAIL ready_onehot: got %b, expected %b", req_ready, 4'b0001 << mon_id);
          end
        end
      end
      if (start_tx) begin
        n_checks++;
        if (req_ready != '0) begin
          n_errors++;
          $display("FAIL start_ready_overlap: ready %b with start_tx, expected 0", req_ready);
        end
        if (exp_sid_q.size() == 0) begin
          n_errors++;
          $display("FAIL start_unexpected: start_tx grant %0d, expected none", grant_id);
        end else begin
          mon_id   = exp_sid_q.pop_front();
          mon_data = exp_sdata_q.pop_front();
          if (grant_id != IdW'(mon_id) || tx_data_out != mon_data) begin
            n_errors++;
            $display("FAIL start_xfer: got id %0d data %h, expected id %0d data %h",
                     grant_id, tx_data_out, mon_id, mon_data);
          end
        end
      end
      if (timeout_err) begin
        n_checks++;
        if (exp_to_q.size() == 0) begin
          n_errors++;
          $display("FAIL timeout_unexpected: timeout_err grant %0d, expected none", grant_id);
        end else begin
          mon_id = exp_to_q.pop_front();
          if (grant_id != IdW'(mon_id)) begin
            n_errors++;
            $display("FAIL timeout_id: got %0d, expected %0d", grant_id, mon_id);
          end
        end
      end
    end
  end

  initial begin
    int n;

    // Reset values
    tick(2);
    check_reset_vals("rst_init");
    presetn = 1'b1;

    // Single request: ready one cycle after the sampling edge, start the cycle after
    enable    = 1'b1;
    req_valid = 4'b0001;
    expect_grant(0, 8'hA5, 1'b1);
    wait_start(n);
    check("single_latency", 32'(n), 32'd3);
    req_valid = '0;
    tick(1);
    check("single_busy", 32'(busy), 32'd1);
    tick(9);
    done_pulse();
    check("single_idle", 32'(busy), 32'd0);

    // Round robin from reset: 0,1,2,3,0
    tick(1);
    presetn = 1'b0;
    tick(1);
    presetn = 1'b1;
    req_valid = 4'b1111;
    expect_grant(0, 8'hA5, 1'b1);
    expect_grant(1, 8'h21, 1'b1);
    expect_grant(2, 8'h32, 1'b1);
    expect_grant(3, 8'h43, 1'b1);
    expect_grant(0, 8'hA5, 1'b1);
    for (int g = 0; g < 5; g++) begin
      wait_start(n);
      if (g == 4) req_valid = '0;
      tick(3);
      done_pulse();
    end

    // Timeout with TIMEOUT_CYCLES=16: tx_done never rises
    req_valid = 4'b0010;
    expect_grant(1, 8'h21, 1'b1);
    exp_to_q.push_back(1);
    wait_start(n);
    req_valid = '0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge pclk);
      if (timeout_err) begin
        n = k;
        break;
      end
    end
    check("timeout_delay", 32'(n), 32'd17);
    check("timeout_idle", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    expect_grant(2, 8'h32, 1'b1);
    wait_start(n);
    req_valid = '0;
    tick(3);
    done_pulse();

    // Stale done level held high before the grant
    tx_done = 1'b1;
    tick(2);
    req_valid = 4'b1000;
    expect_grant(3, 8'h43, 1'b1);
    wait_start(n);
    req_valid = '0;
    tick(6);
    check("stale_busy", 32'(busy), 32'd1);
    tx_done = 1'b0;
    tick(1);
    done_pulse();
    check("stale_fresh_edge", 32'(busy), 32'd0);

    // Requester 2 withdraws in its grant cycle
    req_valid = 4'b0100;
    expect_grant(2, 8'h00, 1'b0);
    tick(1);
    req_valid = '0;
    tick(2);
    check("withdraw_idle", 32'(busy), 32'd0);
    check("withdraw_data", 32'(tx_data_out), 32'h43);
    check("withdraw_grant_id", 32'(grant_id), 32'd2);

    // enable=0 blocks grants; in-flight transfer completes after enable drops
    enable    = 1'b0;
    req_valid = 4'b0001;
    tick(5);
    check("disabled_idle", 32'(busy), 32'd0);
    expect_grant(0, 8'hA5, 1'b1);
    enable = 1'b1;
    wait_start(n);
    enable    = 1'b0;
    req_valid = '0;
    tick(4);
    check("disabled_inflight_busy", 32'(busy), 32'd1);
    done_pulse();
    check("disabled_inflight_done", 32'(busy), 32'd0);

    // Async reset in WAIT_DONE, then requester 0 first again
    enable    = 1'b1;
    req_valid = 4'b0010;
    expect_grant(1, 8'h21, 1'b1);
    wait_start(n);
    req_valid = '0;
    tick(3);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    presetn = 1'b0;
    #1;
    check_reset_vals("rst_async");
    tick(2);
    presetn   = 1'b1;
    req_valid = 4'b0011;
    expect_grant(0, 8'hA5, 1'b1);
    wait_start(n);
    req_valid = '0;
    tick(3);
    done_pulse();

    tick(5);
    check("ready_q_empty", 32'(exp_ready_q.size()), 32'd0);
    check("start_q_empty", 32'(exp_sid_q.size()), 32'd0);
    check("timeout_q_empty", 32'(exp_to_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
